// File: rtl/pixel_row_readout_if.sv
// Sensor configuration defaults and the pixel output stream interface
// (valid/ready handshake carrying one pixel plus its row/column position).
package PixelSensorConfig;
  parameter int PIXEL_ARRAY_WIDTH  = 16;
  parameter int PIXEL_ARRAY_HEIGHT = 16;
  parameter int PIXEL_BITS         = 10;
endpackage

interface pixel_row_readout_if #(
  parameter int WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
  parameter int HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
  parameter int BITS   = PixelSensorConfig::PIXEL_BITS
) ();
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);

  logic [BITS-1:0]  data;
  logic             valid;
  logic             ready;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last;

  modport master (output data, valid, row, col, last, input ready);
  modport slave  (input data, valid, row, col, last, output ready);
endinterface

// File: rtl/pixel_row_readout.sv
// Ping-pong row buffer: captures a sensor row on new_row and streams it out
// one pixel per handshake, flagging dropped rows and bad row selects.
module pixel_row_readout #(
  parameter int WIDTH      = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
  parameter int HEIGHT     = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
  parameter int PIXEL_BITS = PixelSensorConfig::PIXEL_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start_i,
  input  logic                        new_row_i,
  input  logic [HEIGHT-1:0]           row_select_i,
  input  logic [WIDTH*PIXEL_BITS-1:0] pixel_data_i,
  pixel_row_readout_if.master         out_if,
  output logic                        overflow_o,
  output logic                        sel_error_o
);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [PIXEL_BITS-1:0] bank_q [2][WIDTH];
  logic [ROW_W-1:0]      idx_q  [2];

  logic [0:0]       state_q, state_d;
  logic             wp_q, wp_d, rp_q, rp_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             ovf_q, ovf_d, sel_q, sel_d;

  logic             sel_onehot;
  logic [ROW_W-1:0] sel_bin;
  logic             out_valid, handshake, release_row, capture;

  assign sel_onehot = $onehot(row_select_i);

  always_comb begin
    sel_bin = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      if (row_select_i[r]) sel_bin = sel_bin | ROW_W'(r);
    end
  end

  assign out_valid   = (state_q == ST_STREAM);
  assign handshake   = out_valid & out_if.ready;
  assign release_row = handshake & (col_q == COL_LAST);
  // A full buffer still accepts a row when the oldest bank frees this cycle.
  assign capture     = new_row_i & ~frame_start_i & sel_onehot &
                       ((cnt_q != 2'd2) | release_row);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    col_d = col_q;
    ovf_d = ovf_q;
    sel_d = sel_q;
    if (frame_start_i) begin
      wp_d  = 1'b0;
      rp_d  = 1'b0;
      cnt_d = 2'd0;
      col_d = '0;
      ovf_d = 1'b0;
      sel_d = 1'b0;
    end else begin
      if (handshake) begin
        if (release_row) begin
          col_d = '0;
          rp_d  = ~rp_q;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (capture) wp_d = ~wp_q;
      cnt_d = cnt_q + {1'b0, capture} - {1'b0, release_row};
      if (new_row_i && !sel_onehot) sel_d = 1'b1;
      if (new_row_i && sel_onehot && !capture) ovf_d = 1'b1;
    end
    state_d = (cnt_d != 2'd0) ? ST_STREAM : ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= 2'd0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
      sel_q   <= sel_d;
    end
  end

  // Bank contents need no reset: they are only visible while out_valid is high.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
    always_ff @(posedge clk) begin
      if (capture) bank_q[wp_q][gi] <= pixel_data_i[gi*PIXEL_BITS +: PIXEL_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) idx_q[wp_q] <= sel_bin;
  end

  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? bank_q[rp_q][col_q] : '0;
  assign out_if.row   = out_valid ? idx_q[rp_q] : '0;
  assign out_if.col   = out_valid ? col_q : '0;
  assign out_if.last  = out_valid & (idx_q[rp_q] == ROW_LAST) & (col_q == COL_LAST);
  assign overflow_o   = ovf_q;
  assign sel_error_o  = sel_q;
endmodule

// File: tb/tb_pixel_row_readout.sv
// Directed bench for pixel_row_readout with WIDTH=4, HEIGHT=4, PIXEL_BITS=8.
module tb_pixel_row_readout;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, new_row;
  logic [3:0]  row_select;
  logic [31:0] pixel_data;
  logic        overflow, sel_error;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];

  pixel_row_readout_if #(.WIDTH(4), .HEIGHT(4), .BITS(8)) out_if ();

  pixel_row_readout #(.WIDTH(4), .HEIGHT(4), .PIXEL_BITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .new_row_i     (new_row),
    .row_select_i  (row_select),
    .pixel_data_i  (pixel_data),
    .out_if        (out_if),
    .overflow_o    (overflow),
    .sel_error_o   (sel_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] pack(input int r, input int c, input logic [7:0] d);
    logic lst;
    lst = (r == 3) && (c == 3);
    return {19'b0, lst, 2'(r), 2'(c), d};
  endfunction

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [31:0] pix_row(input int r);
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = pix(r, c);
    return v;
  endfunction

  function automatic logic [31:0] obs_pack();
    return {19'b0, out_if.last, out_if.row, out_if.col, out_if.data};
  endfunction

  task automatic push_row(input int r);
    for (int c = 0; c < 4; c++) exp_q.push_back(pack(r, c, pix(r, c)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Score any handshake seen now, then drive inputs for the next edge.
  task automatic cycle(input logic nr, input logic [3:0] rs, input logic [31:0] pd, input logic fs);
    logic [31:0] e;
    if (out_if.valid && out_if.ready) begin
      if (exp_q.size() == 0) begin
        check("extra_pixel", obs_pack(), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pixel", obs_pack(), e);
      end
    end
    new_row = nr;
    row_select = rs;
    pixel_data = pd;
    frame_start = fs;
    step();
    new_row = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    new_row = 1'b0;
    row_select = 4'b0;
    pixel_data = 32'h0;
    out_if.ready = 1'b0;
    #12;
    check("rst_valid", 32'(out_if.valid), 32'd0);
    check("rst_outputs", obs_pack(), 32'd0);
    check("rst_flags", {30'b0, overflow, sel_error}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single row, latency and order
    out_if.ready = 1'b1;
    new_row = 1'b1;
    row_select = 4'b0100;
    pixel_data = 32'h44332211;
    step();
    new_row = 1'b0;
    check("single_latency_valid", 32'(out_if.valid), 32'd1);
    for (int c = 0; c < 4; c++) begin
      logic [7:0] d;
      logic [31:0] v;
      v = 32'h44332211;
      d = v[c*8 +: 8];
      check("single_pixel", obs_pack(), pack(2, c, d));
      step();
    end
    check("single_done_valid", 32'(out_if.valid), 32'd0);

    // Full frame at the 5-cycle sensor cadence
    for (int r = 0; r < 4; r++) push_row(r);
    for (int k = 0; k < 26; k++) begin
      if (k % 5 == 0 && k < 20) cycle(1'b1, 4'(1 << (k / 5)), pix_row(k / 5), 1'b0);
      else idle(1);
    end
    check("frame_drained", 32'(exp_q.size()), 32'd0);
    check("frame_overflow", 32'(overflow), 32'd0);

    // Backpressure: third row dropped, outputs held
    out_if.ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cycle(1'b1, 4'(1 << r), pix_row(r), 1'b0);
      if (r < 2) idle(4);
      check("bp_stall_hold", obs_pack(), pack(0, 0, pix(0, 0)));
    end
    check("bp_overflow", 32'(overflow), 32'd1);
    out_if.ready = 1'b1;
    push_row(0);
    push_row(1);
    idle(12);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_empty_valid", 32'(out_if.valid), 32'd0);
    check("bp_overflow_sticky", 32'(overflow), 32'd1);
    cycle(1'b0, 4'b0000, 32'h0, 1'b1);
    check("bp_overflow_cleared", 32'(overflow), 32'd0);

    // Capture accepted in the same cycle a full buffer releases
    out_if.ready = 1'b0;
    cycle(1'b1, 4'b0001, pix_row(0), 1'b0);
    cycle(1'b1, 4'b0010, pix_row(1), 1'b0);
    check("sim_full_overflow", 32'(overflow), 32'd0);
    out_if.ready = 1'b1;
    push_row(0);
    push_row(1);
    push_row(3);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        check("sim_release_col", 32'(out_if.col), 32'd3);
        cycle(1'b1, 4'b1000, pix_row(3), 1'b0);
      end else begin
        idle(1);
      end
    end
    check("sim_drained", 32'(exp_q.size()), 32'd0);
    check("sim_overflow", 32'(overflow), 32'd0);

    // Bad row selects
    cycle(1'b1, 4'b0000, pix_row(1), 1'b0);
    check("sel_zero_flag", 32'(sel_error), 32'd1);
    cycle(1'b1, 4'b0110, pix_row(2), 1'b0);
    idle(4);
    check("sel_no_output", 32'(out_if.valid), 32'd0);
    check("sel_flags", {30'b0, overflow, sel_error}, 32'd1);
    cycle(1'b0, 4'b0000, 32'h0, 1'b1);
    check("sel_cleared", 32'(sel_error), 32'd0);

    // Async reset mid-row
    cycle(1'b1, 4'b0010, pix_row(1), 1'b0);
    exp_q.push_back(pack(1, 0, pix(1, 0)));
    idle(1);
    check("rst_mid_col", 32'(out_if.col), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_if.valid), 32'd0);
    check("rst_mid_outputs", obs_pack(), 32'd0);
    rst_n = 1'b1;
    idle(8);
    check("rst_mid_no_partial", 32'(exp_q.size()), 32'd0);

    // frame_start mid-row with a simultaneous new_row
    cycle(1'b1, 4'b0100, pix_row(2), 1'b0);
    for (int c = 0; c < 3; c++) exp_q.push_back(pack(2, c, pix(2, c)));
    idle(2);
    check("fs_mid_col", 32'(out_if.col), 32'd2);
    cycle(1'b1, 4'b1000, pix_row(3), 1'b1);
    check("fs_mid_valid", 32'(out_if.valid), 32'd0);
    idle(8);
    check("fs_no_output", 32'(exp_q.size()), 32'd0);
    check("fs_flags", {30'b0, overflow, sel_error}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pixel_row_readout.md
# pixel_row_readout

Downstream readout stage of the pixel sensor: captures the selected row's digitised pixel values when the sensor state machine signals a new row, and streams them out one pixel per handshake. Ping-pong row buffer (two banks) decouples the fixed row-read cadence of the sensor from a backpressuring consumer. Overflow and row-select errors are flagged sticky until the next frame.

## Interface
- PIXEL_ARRAY_WIDTH, default PixelSensorConfig::PIXEL_ARRAY_WIDTH, pixels per row (≥2)
- PIXEL_ARRAY_HEIGHT, default PixelSensorConfig::PIXEL_ARRAY_HEIGHT, rows per frame (≥2)
- PIXEL_BITS, default PixelSensorConfig::PIXEL_BITS, bits per pixel
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- frame_start  in  1  one-cycle pulse; synchronous frame clear
- new_row  in  1  row capture strobe from sensor state
- row_select  in  PIXEL_ARRAY_HEIGHT  one-hot selected row
- pixel_data  in  PIXEL_ARRAY_WIDTH*PIXEL_BITS  selected row's pixels, column c at bits [c*PIXEL_BITS +: PIXEL_BITS]
- out_data  out  PIXEL_BITS  current pixel
- out_valid  out  1  out_data/out_row/out_col/out_last valid
- out_ready  in  1  consumer accepts
- out_row  out  $clog2(PIXEL_ARRAY_HEIGHT)  binary row index of out_data
- out_col  out  $clog2(PIXEL_ARRAY_WIDTH)  column index of out_data
- out_last  out  1  last pixel of frame (row HEIGHT-1, col WIDTH-1)
- overflow  out  1  sticky: a row was dropped (both banks full)
- sel_error  out  1  sticky: new_row with row_select not one-hot

## Operation
- Storage: two banks, each WIDTH pixels + binary row index; write pointer wp, read pointer rp (1 bit each), occupancy cnt 0..2, column counter col.
- Capture: at an edge with new_row=1, sample pixel_data and row_select into bank wp, record one-hot→binary index, wp toggles, cnt+1.
- Capture accepted iff row_select one-hot AND (cnt<2 OR release this cycle). Release this cycle = out_valid & out_ready & col==WIDTH-1.
- new_row with row_select not one-hot (zero or multi-hot): dropped, sel_error←1, no other change.
- new_row with cnt==2 and no release: dropped, overflow←1, buffer untouched.
- Output FSM: EMPTY (cnt==0, out_valid=0) and STREAM (cnt≥1, out_valid=1).
- STREAM: out_data = bank rp column col; out_row = bank rp index; out_col = col.
- Handshake (valid&ready): col<WIDTH-1 → col+1; col==WIDTH-1 → col←0, rp toggles, cnt−1 (net 0 with simultaneous accepted capture).
- out_valid & !out_ready: all outputs held stable; out_valid never deasserts without a handshake (except frame_start/reset).
- out_last = out_valid & out_row==HEIGHT-1 & col==WIDTH-1.
- frame_start: cnt, wp, rp, col, overflow, sel_error ← 0; out_valid drops next cycle; pending rows discarded. Dominates: a new_row in the same cycle is dropped with no flags set.
- Rows stream in capture order; row indices are not checked for sequence.

## Timing
- Reset (reset=0, async): out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, overflow 0, sel_error 0, cnt/wp/rp/col 0. Release is synchronous to clk.
- Capture latency: new_row sampled at edge N into empty buffer → out_valid=1 with column 0 from cycle after edge N.
- Throughput: one pixel per cycle with out_ready=1; a row drains in WIDTH cycles; back-to-back rows with no bubble.
- Sensor cadence row_read_time=5 cycles/row: with out_ready=1 and WIDTH≤5 no overflow ever occurs.
- Flags set at the edge after the offending new_row; cleared only by frame_start or reset.
- Reset mid-stream: outputs go to reset values asynchronously; no partial row emitted afterward.

## Test plan
(bench: WIDTH=4, HEIGHT=4, PIXEL_BITS=8)
- Single row: row_select=4'b0100, pixel_data=32'h44332211, new_row 1 cycle, out_ready=1 → next 4 cycles out_data 11,22,33,44, out_row=2, out_col 0..3, out_last=0, then out_valid=0.
- Full frame at cadence: rows 0..3 every 5 cycles, pixel = {row,col} nibbles, out_ready=1 → 16 pixels in order, out_last=1 only on row 3 col 3, overflow=0.
- Backpressure: out_ready=0 while rows 0,1,2 arrive → banks hold rows 0,1, row 2 dropped, overflow=1; then out_ready=1 → 8 pixels of rows 0,1 only, outputs stable during stall.
- Simultaneous release+capture: cnt=2, out_ready=1 on col 3 while new_row for row 3 → row 3 accepted, overflow stays 0, streamed after following row.
- Bad select: new_row with row_select=4'b0000 then 4'b0110 → no output, sel_error=1; frame_start → sel_error=0.
- Reset/frame_start mid-row: assert reset=0 at col 1 → out_valid=0 immediately; separately frame_start at col 2 → out_valid=0 next cycle, same-cycle new_row produces no output.
